// File: rtl/kd_tree_sequencer_if.sv
// Node-load, query and result valid/ready channels of kd_tree_sequencer.
// master: aggregator/query source/result sink; slave: sequencer.
interface kd_tree_sequencer_if #(
  parameter int NODE_WIDTH  = 22,
  parameter int PATCH_WIDTH = 55,
  parameter int LEAF_WIDTH  = 8
);
  logic                   node_valid;
  logic [NODE_WIDTH-1:0]  node_data;
  logic                   node_ready;
  logic                   q_valid;
  logic [PATCH_WIDTH-1:0] q_patch;
  logic                   q_ready;
  logic                   res_valid;
  logic [LEAF_WIDTH-1:0]  res_leaf;
  logic                   res_ready;

  modport master (
    output node_valid, node_data,
    output q_valid, q_patch, res_ready,
    input  node_ready, q_ready,
    input  res_valid, res_leaf
  );

  modport slave (
    input  node_valid, node_data,
    input  q_valid, q_patch, res_ready,
    output node_ready, q_ready,
    output res_valid, res_leaf
  );
endinterface

// File: rtl/kd_tree_sequencer.sv
// Sequences the kd-tree engine: load NUM_NODES words, then serve queries.
// Ports: clk, wrst_n (sync low), start, bus (slave), tree_* to/from tree,
// loaded / nodes_loaded load status.
module kd_tree_sequencer #(
  parameter int NODE_WIDTH     = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int LEAF_WIDTH     = 8,
  parameter int NUM_NODES      = 63,
  parameter int NODE_CNT_WIDTH = 6,
  parameter int TREE_LATENCY   = 6,
  parameter int LAT_CNT_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      wrst_n,
  input  logic                      start,
  kd_tree_sequencer_if.slave        bus,
  output logic                      tree_fsm_enable,
  output logic                      tree_sender_enable,
  output logic [NODE_WIDTH-1:0]     tree_sender_data,
  output logic [PATCH_WIDTH-1:0]    tree_patch_in,
  input  logic [LEAF_WIDTH-1:0]     tree_leaf_index,
  output logic                      loaded,
  output logic [NODE_CNT_WIDTH-1:0] nodes_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_QUERY,
    S_RESULT
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [NODE_CNT_WIDTH-1:0] r_cnt;
  logic                      r_loaded;
  logic [LAT_CNT_WIDTH-1:0]  r_lat;
  logic [PATCH_WIDTH-1:0]    r_patch;
  logic [LEAF_WIDTH-1:0]     r_leaf;

  logic w_node_acc;
  logic w_q_acc;
  logic w_last;
  logic w_lat_done;
  logic w_clr;

  assign bus.node_ready = (r_state == S_LOAD);
  assign bus.q_ready    = (r_state == S_READY);
  assign bus.res_valid  = (r_state == S_RESULT);
  assign bus.res_leaf   = r_leaf;
  assign tree_fsm_enable = (r_state == S_LOAD);

  assign w_node_acc = bus.node_valid & bus.node_ready;
  assign w_q_acc    = bus.q_valid & bus.q_ready;
  assign w_last     = r_cnt == NODE_CNT_WIDTH'(NUM_NODES - 1);
  assign w_lat_done = r_lat == LAT_CNT_WIDTH'(TREE_LATENCY - 1);

  // A query in READY takes priority over a reload request.
  assign w_clr = start &
                 ((r_state == S_IDLE) |
                  ((r_state == S_READY) & ~bus.q_valid));

  assign tree_sender_enable = w_node_acc;
  assign tree_sender_data   = bus.node_data;
  assign tree_patch_in      = r_patch;
  assign loaded             = r_loaded;
  assign nodes_loaded       = r_cnt;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   if (w_node_acc && w_last) w_next = S_READY;
      S_READY: begin
        if (bus.q_valid)  w_next = S_QUERY;
        else if (start)   w_next = S_LOAD;
      end
      S_QUERY:  if (w_lat_done) w_next = S_RESULT;
      S_RESULT: if (bus.res_ready) w_next = S_READY;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!wrst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_lat    <= '0;
      r_patch  <= '0;
      r_leaf   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_cnt    <= '0;
        r_loaded <= 1'b0;
      end else if (w_node_acc) begin
        r_cnt <= r_cnt + NODE_CNT_WIDTH'(1);
        if (w_last) r_loaded <= 1'b1;
      end
      if (w_q_acc) begin
        r_patch <= bus.q_patch;
        r_lat   <= '0;
      end else if (r_state == S_QUERY) begin
        r_lat <= r_lat + LAT_CNT_WIDTH'(1);
      end
      if (r_state == S_QUERY && w_lat_done)
        r_leaf <= tree_leaf_index;
    end
  end

endmodule
